// File: rtl/paralelo_serial_tx_sync.sv
// paralelo_serial_tx_sync
//   Link-layer TX serializer. Turns WIDTH-bit parallel words into a 1-bit,
//   MSB-first stream clocked by clk_32f. After reset or after the link drops,
//   it sends at least COM_MIN comma symbols. Once the link is active, it sends
//   offered data words and fills the gaps with IDLE symbols.
//
// Ports:
//   clk_32f        in   serial bit clock; all state changes on its rising edge
//   default_values in   asynchronous active-high reset
//   active         in   link-up indication from RX alignment, sampled at boundaries
//   data_in        in   [WIDTH] parallel word to transmit
//   valid_in       in   data_in holds a valid word
//   ready_out      out  combinational; word accepted when ready_out && valid_in
//   data_out       out  serial bit (MSB of the shift register)
//   sym_start      out  high while the MSB of a symbol is on data_out
//   link_up        out  high while in the ACTIVE state
module paralelo_serial_tx_sync #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] COM_SYM  = 8'hBC,
    parameter logic [WIDTH-1:0] IDLE_SYM = 8'h7C,
    parameter int unsigned      COM_MIN  = 4
) (
    input  logic             clk_32f,
    input  logic             default_values,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             sym_start,
    output logic             link_up
);

    localparam int unsigned CW = $clog2(COM_MIN + 1);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] COM_DONE = CW'(COM_MIN);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    com_cnt, com_cnt_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg, sym_nxt;
    logic             sym_start_q;
    logic             boundary;
    logic             com_done;

    assign boundary = (bit_cnt == BIT_LAST);
    assign com_done = (com_cnt == COM_DONE);

    // State register
    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            state   <= SYNC;
            com_cnt <= '0;
        end else begin
            state   <= state_nxt;
            com_cnt <= com_cnt_nxt;
        end
    end

    // Next-state and symbol selection; only boundary cycles change anything
    always_comb begin
        state_nxt   = state;
        com_cnt_nxt = com_cnt;
        sym_nxt     = valid_in ? data_in : IDLE_SYM;
        if (boundary) begin
            case (state)
                SYNC: begin
                    if (com_done && active) begin
                        state_nxt = ACTIVE;
                    end else begin
                        sym_nxt = COM_SYM;
                        if (!com_done) begin
                            com_cnt_nxt = com_cnt + CW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    if (!active) begin
                        // Counter clears on the drop, but the COM loaded at this
                        // same boundary already counts toward the burst.
                        state_nxt   = SYNC;
                        com_cnt_nxt = CW'(1);
                        sym_nxt     = COM_SYM;
                    end
                end
                default: begin
                    state_nxt = SYNC;
                end
            endcase
        end
    end

    // Serial datapath: load at the boundary, otherwise shift left
    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            bit_cnt     <= BIT_LAST;
            shreg       <= '0;
            sym_start_q <= 1'b0;
        end else begin
            sym_start_q <= boundary;
            if (boundary) begin
                bit_cnt <= '0;
                shreg   <= sym_nxt;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Outputs
    always_comb begin
        ready_out = active && boundary && ((state == ACTIVE) || com_done);
        data_out  = shreg[WIDTH-1];
        sym_start = sym_start_q;
        link_up   = (state == ACTIVE);
    end

endmodule

// File: tb/tb_paralelo_serial_tx_sync.sv
// tb_paralelo_serial_tx_sync
//   Randomised bench for paralelo_serial_tx_sync. A symbol-level reference
//   model decides what each symbol must be and queues it; a monitor
//   deserializes data_out on sym_start and compares whole symbols plus link_up.
module tb_paralelo_serial_tx_sync;

    localparam int unsigned  W    = 8;
    localparam logic [W-1:0] COM  = 8'hBC;
    localparam logic [W-1:0] IDLE = 8'h7C;
    localparam int unsigned  CMIN = 4;

    logic         clk_32f = 1'b0;
    logic         default_values;
    logic         active;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic         data_out;
    logic         sym_start;
    logic         link_up;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial_tx_sync #(
        .WIDTH    (W),
        .COM_SYM  (COM),
        .IDLE_SYM (IDLE),
        .COM_MIN  (CMIN)
    ) dut (
        .clk_32f        (clk_32f),
        .default_values (default_values),
        .active         (active),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .sym_start      (sym_start),
        .link_up        (link_up)
    );

    typedef struct {
        logic [W-1:0] sym;
        logic         link;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state: position within the symbol, link status, COMs sent
    int unsigned  k;
    bit           linked;
    int unsigned  coms;
    bit           act;
    logic         p_valid;
    logic [W-1:0] p_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // mode 0: link down; 1: link up, nothing offered; 2: random; 3: back-to-back words
    task automatic drive_and_eval(input int mode);
        logic   vin;
        logic   exp_rdy;
        exp_t   e;
        case (mode)
            0:       act = 1'b0;
            1, 3:    act = 1'b1;
            default: if ($urandom_range(0, 49) == 0) act = !act;
        endcase
        if (!p_valid && (mode == 3 || $urandom_range(0, 3) != 0)) begin
            p_valid = 1'b1;
            p_data  = W'($urandom);
        end
        vin      = (mode == 1) ? 1'b0 : p_valid;
        active   = act;
        valid_in = vin;
        data_in  = p_data;
        #1;
        exp_rdy = (k == W - 1) && act && (linked || coms >= CMIN);
        chk("ready_out", 32'(ready_out), 32'(exp_rdy));
        if (k == W - 1) begin
            if (!linked && coms >= CMIN && act) begin
                linked = 1'b1;
            end else if (linked && !act) begin
                linked = 1'b0;
                coms   = 0;
            end
            if (linked) begin
                e.sym = vin ? p_data : IDLE;
                if (vin) p_valid = 1'b0;
            end else begin
                e.sym = COM;
                if (coms < CMIN) coms++;
            end
            e.link = linked;
            exp_q.push_back(e);
            k = 0;
        end else begin
            k++;
        end
    endtask

    task automatic step(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            drive_and_eval(mode);
        end
    endtask

    task automatic release_reset(input int mode);
        @(negedge clk_32f);
        default_values = 1'b0;
        k      = W - 1;
        linked = 1'b0;
        coms   = 0;
        drive_and_eval(mode);
    endtask

    task automatic mid_reset();
        @(negedge clk_32f);
        #2;
        default_values = 1'b1;
        #1;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_sym_start", 32'(sym_start), 32'd0);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_32f);
    endtask

    // Monitor: rebuild each symbol from the serial line and compare
    initial begin
        int           nb   = 0;
        int           idle = 0;
        bit           coll = 0;
        logic [W-1:0] sh   = '0;
        exp_t         e;
        forever begin
            @(negedge clk_32f);
            if (default_values !== 1'b0) begin
                coll = 0;
                nb   = 0;
                idle = 0;
            end else begin
                if (sym_start === 1'b1) begin
                    if (coll && nb != W) begin
                        chk("sym_start_early", 32'(nb), 32'(W));
                    end
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_symbol", 32'd1, 32'd0);
                        coll = 0;
                    end else begin
                        e    = exp_q.pop_front();
                        coll = 1;
                        nb   = 0;
                    end
                end else if (coll && nb == W) begin
                    chk("sym_start_missing", 32'(sym_start), 32'd1);
                    coll = 0;
                end
                if (coll) begin
                    sh = {sh[W-2:0], data_out};
                    nb++;
                    chk("link_up", 32'(link_up), 32'(e.link));
                    if (nb == W) chk("symbol", 32'(sh), 32'(e.sym));
                end else begin
                    idle++;
                    if (idle == 2 * W) chk("no_sym_start", 32'd0, 32'd1);
                end
            end
        end
    end

    initial begin
        default_values = 1'b1;
        active         = 1'b1;
        valid_in       = 1'b1;
        data_in        = '1;
        act            = 1'b0;
        p_valid        = 1'b0;
        p_data         = '0;
        k              = W - 1;
        linked         = 1'b0;
        coms           = 0;
        repeat (3) @(negedge clk_32f);
        chk("init_data_out", 32'(data_out), 32'd0);
        chk("init_sym_start", 32'(sym_start), 32'd0);
        chk("init_link_up", 32'(link_up), 32'd0);
        chk("init_ready_out", 32'(ready_out), 32'd0);

        // Link down: COM repeats forever
        release_reset(0);
        step(0, 64);
        // Link comes up with nothing to send: IDLE after the COM burst
        step(1, 80);
        // Continuous traffic at full rate
        step(3, 48);
        step(2, 1500);
        // Reset while streaming data, then restart the COM burst
        step(3, 37);
        mid_reset();
        release_reset(0);
        step(0, 40);
        step(1, 60);
        step(2, 2000);
        step(3, 13);
        mid_reset();
        release_reset(1);
        step(1, 50);
        step(2, 1500);
        step(1, 3 * W);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/paralelo_serial_tx_sync.md
Name: paralelo_serial_tx_sync

Overview:
- Parametrised PHY-side serializer: converts WIDTH-bit parallel words to a 1-bit MSB-first stream at clk_32f, one bit per cycle.
- Generalises the fixed COM/IDLE symbol emitter into a full link-layer TX front end.
- After reset, sends a mandatory burst of COM symbols. Once the link is active, sends data words when offered, otherwise IDLE symbols.
- Sits between the TX logic (parallel side) and the serial line feeding serial_paralelo on the RX side.

Parameters:
- WIDTH, 8, symbol/word width in bits (>=2).
- COM_SYM, 8'hBC, comma/alignment symbol (WIDTH bits).
- IDLE_SYM, 8'h7C, idle filler symbol (WIDTH bits).
- COM_MIN, 4, minimum COM symbols sent after reset or after active drops, before data/idle is allowed (>=1).

Ports:
- clk_32f  input  1  serial bit clock; all state changes on rising edge.
- default_values  input  1  reset, asynchronous, active-high.
- active  input  1  link-up indication from RX alignment; sampled only at symbol boundaries.
- data_in  input  WIDTH  parallel word to transmit.
- valid_in  input  1  data_in holds a valid word.
- ready_out  output  1  combinational; a word is accepted in a cycle when ready_out && valid_in.
- data_out  output  1  serial bit, equals MSB of the shift register (registered).
- sym_start  output  1  registered; high during the cycle the MSB of each symbol is on data_out.
- link_up  output  1  registered; 1 while in ACTIVE state.

Behaviour:
- Reset (async, default_values=1):
  - State=SYNC, com_cnt=0, bit_cnt=WIDTH-1, shift register=0.
  - data_out=0, sym_start=0, link_up=0.
  - Reset asserted mid-symbol aborts the symbol immediately; no partial-symbol completion.
- Bit counter:
  - bit_cnt runs 0..WIDTH-1, wraps every WIDTH cycles.
  - The boundary cycle is bit_cnt==WIDTH-1. At the edge ending the boundary cycle, the next symbol loads and bit_cnt becomes 0.
  - Otherwise the register shifts left one bit per cycle.
- First edge after reset release is a boundary, so the first COM MSB appears on data_out with sym_start=1 one cycle after release.
- com_cnt:
  - Increments on each COM load, saturating at COM_MIN.
  - Width is clog2(COM_MIN+1).
- Symbol selection at each boundary:
  - SYNC, and (com_cnt<COM_MIN or active=0): load COM_SYM; stay in SYNC.
  - SYNC, com_cnt==COM_MIN and active=1: go to ACTIVE; link_up=1 from the next cycle; load the data/idle selection below.
  - ACTIVE, active=1: if valid_in, load data_in (word consumed); else load IDLE_SYM.
  - ACTIVE, active=0: go to SYNC, com_cnt cleared to 0, load COM_SYM; link_up=0 from the next cycle.
- ready_out = active && (bit_cnt==WIDTH-1) && (state==ACTIVE || com_cnt==COM_MIN).
  - Never high outside boundary cycles or during reset.
  - A word is consumed exactly when ready_out && valid_in.
  - valid_in with ready_out=0 is held by the producer; nothing is dropped or duplicated.
- active changes between boundaries have no effect; an in-flight symbol (including data) always completes all WIDTH bits.
- Data loaded uses the data_in value present in the boundary cycle.
- sym_start=1 exactly in cycles where bit_cnt==0 after reset release; period is WIDTH cycles.
- Back-to-back words:
  - Continuous valid_in with active=1 gives one word per WIDTH cycles, no gaps.
  - Throughput is 100% of line rate.

Test Plan:
- Reset release with active=0, 64 cycles: data_out serializes 8'hBC repeatedly (1,0,1,1,1,1,0,0…). sym_start every 8 cycles starting cycle 1. ready_out, link_up stay 0.
- Reset release with active=1 held, valid_in=0: first 4 symbols are BC. ready_out pulses on the 5th boundary (cycle 32). Symbol 5 onward is 7C. link_up=1 from cycle 33.
- Link up, valid_in=1, data_in sequence 8'hA5, 8'h3C, 8'hFF: serial bits A5, 3C, FF back-to-back MSB first. Exactly three accept pulses, 8 cycles apart. Then 7C after valid_in drops.
- Link up, active deasserted mid-data-symbol (bit 3 of 8'h96): 8'h96 completes fully. Then exactly 4 BC symbols. Then 7C resumes, assuming active is back to 1 by the 4th-COM boundary. link_up low during the COM burst.
- default_values asserted mid-symbol while sending data: data_out, sym_start, link_up are 0 in the same cycle without waiting for a clock edge. After release, behaviour matches the first scenario (COM burst restarts, com_cnt=0).
- WIDTH=10, COM_SYM=10'h17C, IDLE_SYM=10'h283, COM_MIN=2: sym_start period 10. Two COM symbols precede IDLE. Data accepted every 10 cycles.
